// File: rtl/cl_pkg.sv
// Shared constants and FSM state encoding for the cache-line FIFO scheduler.
package cl_pkg;

  localparam int CL          = 512;
  localparam int NUM_CH      = 4;
  localparam int W_CH        = 2;
  localparam int GAP_DEF     = 16;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

endpackage

// File: rtl/cl_fifo_sched_rr_arbiter.sv
// Round-robin priority search: first requester after the last grant, with wrap.
module rr_arbiter #(
  parameter int NUM_CH = cl_pkg::NUM_CH,
  parameter int W_CH   = cl_pkg::W_CH
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [W_CH-1:0]   last_grant,
  output logic [W_CH-1:0]   winner,
  output logic              valid
);

  logic [W_CH-1:0] idx;

  // Walk the channels starting one past the last grant; the first hit wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = W_CH'((int'(last_grant) + i) % NUM_CH);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/cl_fifo_sched.sv
// Frame scheduler: grants one CL FIFO at a time to the CL-to-ST converter,
// watches for stalled frames, and enforces an idle gap between frames.
module cl_fifo_sched #(
  parameter int CL      = cl_pkg::CL,
  parameter int NUM_CH  = cl_pkg::NUM_CH,
  parameter int W_CH    = cl_pkg::W_CH,
  parameter int GAP     = cl_pkg::GAP_DEF,
  parameter int TIMEOUT = cl_pkg::TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n_sync,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [NUM_CH-1:0]    ch_rd_ready,
  input  logic [NUM_CH*CL-1:0] ch_q,
  output logic [NUM_CH-1:0]    ch_rdreq,
  output logic [NUM_CH-1:0]    ch_rd_finish,
  output logic                 cv_rd_ready,
  input  logic                 cv_rdreq,
  output logic [CL-1:0]        cv_q,
  input  logic                 cv_rd_finish,
  output logic [W_CH-1:0]      grant_id,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_timeout
);

  import cl_pkg::*;

  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  state_e            state_q, state_d;
  logic [W_CH-1:0]   grant_q, grant_d;
  logic [W_CH-1:0]   last_q, last_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              frame_done_q, frame_done_d;
  logic              err_timeout_q, err_timeout_d;

  logic [W_CH-1:0]   arb_winner;
  logic              arb_valid;
  logic [NUM_CH-1:0] grant_oh;
  logic              active;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .W_CH   (W_CH)
  ) u_rr_arbiter (
    .req        (ch_rd_ready & ch_en),
    .last_grant (last_q),
    .winner     (arb_winner),
    .valid      (arb_valid)
  );

  // One-hot view of the current grant, used to steer rdreq/finish.
  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  // Next-state logic: grant, launch, run the frame under watchdog, then hold off.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    wdog_d        = wdog_q;
    gap_d         = gap_q;
    frame_done_d  = 1'b0;
    err_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_winner;
          last_d  = arb_winner;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wdog_d  = '0;
        state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Finish takes priority over a coincident watchdog expiry.
        if (cv_rd_finish) begin
          frame_done_d = 1'b1;
          gap_d        = '0;
          state_d      = ST_HOLDOFF;
        end else if (cv_rdreq) begin
          wdog_d = '0;
        end else if (wdog_q == WD_LAST) begin
          err_timeout_d = 1'b1;
          gap_d         = '0;
          state_d       = ST_HOLDOFF;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; reset abandons any frame without pulses.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_q        <= W_CH'(NUM_CH - 1);
      wdog_q        <= '0;
      gap_q         <= '0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      wdog_q        <= wdog_d;
      gap_q         <= gap_d;
      frame_done_q  <= frame_done_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Converter handshakes only pass through while a frame is active; all
  // combinational strobes are held low while reset is asserted.
  assign active       = rst_n_sync && (state_q == ST_ACTIVE);
  assign ch_rdreq     = (active && cv_rdreq) ? grant_oh : '0;
  assign ch_rd_finish = (active && cv_rd_finish) ? grant_oh : '0;
  assign cv_rd_ready  = rst_n_sync && (state_q == ST_LAUNCH);
  assign busy         = rst_n_sync && (state_q != ST_IDLE);
  assign cv_q         = ch_q[grant_q*CL +: CL];
  assign grant_id     = grant_q;
  assign frame_done   = frame_done_q;
  assign err_timeout  = err_timeout_q;

endmodule
